// File: rtl/latch_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// latch_write_arbiter_if
// Bundles the requester side and latch side signals of the latch write
// arbiter.
//   req      : per-requester write request (level, held until own done bit)
//   wdata    : packed requester data, slice i = wdata[i*DATA_W +: DATA_W]
//   q_in     : readback from the latch q output
//   grant    : one-hot current owner, 0 when idle
//   latch_d  : data presented to the latch d input
//   latch_en : latch enable (gate input)
//   done     : one-cycle pulse on the owner's bit at transaction end
//   err      : one-cycle pulse alongside done when the readback mismatched
//   busy     : high while a transaction is in progress
// The slave modport is the arbiter side; master is the requester/latch side.
// ---------------------------------------------------------------------------
interface latch_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]       q_in;
    logic [N_REQ-1:0]        grant;
    logic [DATA_W-1:0]       latch_d;
    logic                    latch_en;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic                    busy;

    modport slave (
        input  req, wdata, q_in,
        output grant, latch_d, latch_en, done, err, busy
    );

    modport master (
        output req, wdata, q_in,
        input  grant, latch_d, latch_en, done, err, busy
    );
endinterface

// File: rtl/latch_write_arbiter.sv
// ---------------------------------------------------------------------------
// latch_write_arbiter
// Round-robin arbiter plus write sequencer sharing one level-sensitive latch
// register among N_REQ requesters. The winner's data is driven on latch_d,
// the latch is opened for EN_CYC cycles between SETUP_CYC setup and HOLD_CYC
// hold cycles, and the latch output is read back on the last hold cycle.
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous, active-high reset
//   bus : latch_write_arbiter_if.slave (req/wdata/q_in in;
//         grant/latch_d/latch_en/done/err/busy out, all registered)
// ---------------------------------------------------------------------------
module latch_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    latch_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [3:0]         phase_q, phase_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               latch_en_q, latch_en_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   masked_req;
    logic               found;
    logic [PTR_W-1:0]   win;

    function automatic logic last_cyc(input logic [3:0] ph, input int n);
        return ph == 4'(n - 1);
    endfunction

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        wr_data_d  = wr_data_q;
        done_d     = '0;
        err_d      = 1'b0;
        found      = 1'b0;
        win        = '0;

        // The requester that just completed is masked for one cycle so the
        // IDLE cycle carrying done cannot hand it the bus straight back.
        masked_req = bus.req & ~done_q;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && masked_req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = SETUP;
                    phase_d        = '0;
                    ptr_d          = win;
                    grant_d        = '0;
                    grant_d[win]   = 1'b1;
                    wr_data_d      = bus.wdata[int'(win)*DATA_W +: DATA_W];
                end
            end
            SETUP: begin
                if (last_cyc(phase_q, SETUP_CYC)) begin
                    state_d = ENABLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ENABLE: begin
                if (last_cyc(phase_q, EN_CYC)) begin
                    state_d = HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            HOLD: begin
                if (last_cyc(phase_q, HOLD_CYC)) begin
                    state_d = IDLE;
                    phase_d = '0;
                    grant_d = '0;
                    done_d  = grant_q;
                    err_d   = (bus.q_in != wr_data_q);
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // Registered enable: high exactly for the cycles spent in ENABLE.
        latch_en_d = (state_d == ENABLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            ptr_q      <= PTR_W'(N_REQ - 1);
            grant_q    <= '0;
            wr_data_q  <= '0;
            latch_en_q <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            wr_data_q  <= wr_data_d;
            latch_en_q <= latch_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.latch_d  = wr_data_q;
    assign bus.latch_en = latch_en_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
